if_fetch_unit: RTL and testbench

Instruction-fetch stage of the five-stage ARM pipeline. It is the producing end of the IF/ID interface whose consumer is the decode stage. It owns the program counter and drives a request/ready handshake to instruction memory. It holds the IF/ID pipeline register, which supplies `pc` and `instruction` to decode, obeys the decode-side freeze (hazard or multi-cycle instruction freeze), and redirects on a taken branch from execute.

---
 rtl/if_fetch_unit_if.sv | 25 ++
 rtl/if_fetch_unit.sv | 119 +++++++++++
 tb/tb_if_fetch_unit.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - instruction-memory request/ready bus between fetch and imem
interface if_fetch_unit_if #(
  parameter int ADDRESS_LEN = 32
);
  logic                   imem_req;
  logic [ADDRESS_LEN-1:0] imem_addr;
  logic                   imem_ready;
  logic [ADDRESS_LEN-1:0] imem_rdata;

  // Fetch unit drives the request side
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  // Instruction memory answers
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - IF stage: PC, imem handshake, hold buffer and IF/ID register
module if_fetch_unit #(
  parameter int                     ADDRESS_LEN = 32,
  parameter logic [ADDRESS_LEN-1:0] RESET_PC    = '0,
  parameter logic [ADDRESS_LEN-1:0] NOP_INSTR   = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   branch_taken,
  input  logic [ADDRESS_LEN-1:0] branch_addr,
  if_fetch_unit_if.master        imem,
  output logic [ADDRESS_LEN-1:0] pc,
  output logic [ADDRESS_LEN-1:0] instruction,
  output logic                   valid
);

  typedef enum logic [0:0] {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  localparam logic [ADDRESS_LEN-1:0] PC_STEP = ADDRESS_LEN'(4);

  state_t                 state_q,    state_d;
  logic [ADDRESS_LEN-1:0] pc_reg_q,   pc_reg_d;
  logic [ADDRESS_LEN-1:0] hb_instr_q, hb_instr_d;
  logic [ADDRESS_LEN-1:0] hb_pc_q,    hb_pc_d;
  logic [ADDRESS_LEN-1:0] if_pc_q,    if_pc_d;
  logic [ADDRESS_LEN-1:0] if_instr_q, if_instr_d;
  logic                   if_valid_q, if_valid_d;
  logic [ADDRESS_LEN-1:0] pc_inc;

  // Increment wraps naturally at 2^ADDRESS_LEN
  assign pc_inc = pc_reg_q + PC_STEP;

  // No request while parked in the hold buffer or held in reset
  assign imem.imem_req  = (state_q == S_REQ) && !rst;
  assign imem.imem_addr = pc_reg_q;

  assign pc          = if_pc_q;
  assign instruction = if_instr_q;
  assign valid       = if_valid_q;

  // Next-state: branch redirect first, then fetch/freeze handling per state
  always_comb begin
    state_d    = state_q;
    pc_reg_d   = pc_reg_q;
    hb_instr_d = hb_instr_q;
    hb_pc_d    = hb_pc_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;

    if (branch_taken) begin
      // Flush overrides freeze and drops any same-cycle response or buffered word
      pc_reg_d   = branch_addr;
      if_pc_d    = '0;
      if_instr_d = NOP_INSTR;
      if_valid_d = 1'b0;
      hb_instr_d = '0;
      hb_pc_d    = '0;
      state_d    = S_REQ;
    end else begin
      case (state_q)
        S_REQ: begin
          if (imem.imem_ready) begin
            pc_reg_d = pc_inc;
            if (!freeze) begin
              if_pc_d    = pc_inc;
              if_instr_d = imem.imem_rdata;
              if_valid_d = 1'b1;
            end else begin
              // Decode is stalled: park the word so it is neither lost nor refetched
              hb_pc_d    = pc_inc;
              hb_instr_d = imem.imem_rdata;
              state_d    = S_HOLD;
            end
          end else if (!freeze) begin
            // Memory stall becomes a bubble; pc field keeps its old value
            if_instr_d = NOP_INSTR;
            if_valid_d = 1'b0;
          end
        end
        S_HOLD: begin
          if (!freeze) begin
            if_pc_d    = hb_pc_q;
            if_instr_d = hb_instr_q;
            if_valid_d = 1'b1;
            state_d    = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  // State and pipeline registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_reg_q   <= RESET_PC;
      hb_instr_q <= '0;
      hb_pc_q    <= '0;
      if_pc_q    <= '0;
      if_instr_q <= NOP_INSTR;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_reg_q   <= pc_reg_d;
      hb_instr_q <= hb_instr_d;
      hb_pc_q    <= hb_pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed table-driven bench for if_fetch_unit
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'hE1A0_0000;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        valid;

  if_fetch_unit_if #(.ADDRESS_LEN(32)) bus ();

  if_fetch_unit #(
    .ADDRESS_LEN(32),
    .RESET_PC   (32'h0000_0000),
    .NOP_INSTR  (NOP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .branch_taken(branch_taken),
    .branch_addr (branch_addr),
    .imem        (bus),
    .pc          (pc),
    .instruction (instruction),
    .valid       (valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        frz;
    logic        br;
    logic [31:0] baddr;
    logic        rdy;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    logic        e_v;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic r, logic f, logic b, logic [31:0] ba, logic rd,
                              logic [31:0] dat, logic eq, logic [31:0] ea,
                              logic [31:0] ep, logic [31:0] ei, logic ev);
    vec_t v;
    v.rst = r; v.frz = f; v.br = b; v.baddr = ba; v.rdy = rd; v.rdata = dat;
    v.e_req = eq; v.e_addr = ea; v.e_pc = ep; v.e_ins = ei; v.e_v = ev;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
    bus.imem_ready = 1'b0; bus.imem_rdata = '0;

    //        rst frz br baddr         rdy rdata               req addr          pc            instr               v
    vecs.push_back(mk(0,0,0,32'h0,       1, 32'h0 ^KEY,          1, 32'h00,      32'h04,       KEY ^ 32'h00,       1));
    vecs.push_back(mk(0,0,0,32'h0,       1, 32'h4 ^KEY,          1, 32'h04,      32'h08,       KEY ^ 32'h04,       1));
    vecs.push_back(mk(0,0,0,32'h0,       0, 32'hBAD0_0001,       1, 32'h08,      32'h08,       NOP,                0));
    vecs.push_back(mk(0,0,0,32'h0,       0, 32'hBAD0_0002,       1, 32'h08,      32'h08,       NOP,                0));
    vecs.push_back(mk(0,0,0,32'h0,       1, 32'h8 ^KEY,          1, 32'h08,      32'h0C,       KEY ^ 32'h08,       1));
    vecs.push_back(mk(0,0,0,32'h0,       1, 32'hC ^KEY,          1, 32'h0C,      32'h10,       KEY ^ 32'h0C,       1));
    vecs.push_back(mk(0,1,0,32'h0,       1, 32'h10^KEY,          1, 32'h10,      32'h10,       KEY ^ 32'h0C,       1));
    vecs.push_back(mk(0,1,0,32'h0,       1, 32'hDEAD_BEEF,       0, 32'h14,      32'h10,       KEY ^ 32'h0C,       1));
    vecs.push_back(mk(0,1,0,32'h0,       0, 32'hDEAD_BEEF,       0, 32'h14,      32'h10,       KEY ^ 32'h0C,       1));
    vecs.push_back(mk(0,0,0,32'h0,       1, 32'hDEAD_BEEF,       0, 32'h14,      32'h14,       KEY ^ 32'h10,       1));
    vecs.push_back(mk(0,0,0,32'h0,       1, 32'h14^KEY,          1, 32'h14,      32'h18,       KEY ^ 32'h14,       1));
    vecs.push_back(mk(0,0,0,32'h0,       1, 32'h18^KEY,          1, 32'h18,      32'h1C,       KEY ^ 32'h18,       1));
    vecs.push_back(mk(0,0,0,32'h0,       1, 32'h1C^KEY,          1, 32'h1C,      32'h20,       KEY ^ 32'h1C,       1));
    vecs.push_back(mk(0,0,0,32'h0,       0, 32'h0,               1, 32'h20,      32'h20,       NOP,                0));
    vecs.push_back(mk(0,0,1,32'h40,      1, 32'h20^KEY,          1, 32'h20,      32'h00,       NOP,                0));
    vecs.push_back(mk(0,0,0,32'h0,       1, 32'h40^KEY,          1, 32'h40,      32'h44,       KEY ^ 32'h40,       1));
    vecs.push_back(mk(0,1,0,32'h0,       1, 32'h44^KEY,          1, 32'h44,      32'h44,       KEY ^ 32'h40,       1));
    vecs.push_back(mk(0,1,1,32'h80,      0, 32'h0,               0, 32'h48,      32'h00,       NOP,                0));
    vecs.push_back(mk(0,0,0,32'h0,       1, 32'h80^KEY,          1, 32'h80,      32'h84,       KEY ^ 32'h80,       1));
    vecs.push_back(mk(0,1,0,32'h0,       1, 32'h84^KEY,          1, 32'h84,      32'h84,       KEY ^ 32'h80,       1));
    vecs.push_back(mk(1,1,0,32'h0,       1, 32'h0,               0, 32'h88,      32'h00,       NOP,                0));
    vecs.push_back(mk(0,0,0,32'h0,       1, 32'h0 ^KEY,          1, 32'h00,      32'h04,       KEY ^ 32'h00,       1));
    vecs.push_back(mk(0,0,1,32'hFFFF_FFFC,0,32'h0,               1, 32'h04,      32'h00,       NOP,                0));
    vecs.push_back(mk(0,0,0,32'h0,       1, 32'h1234_5678,       1, 32'hFFFF_FFFC,32'h00,      32'h1234_5678,      1));
    vecs.push_back(mk(0,0,0,32'h0,       0, 32'h0,               1, 32'h00,      32'h00,       NOP,                0));

    // Reset state: two edges under reset, rst still high
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_req",   {31'b0, bus.imem_req}, 32'h0);
    chk("rst_addr",  bus.imem_addr, 32'h0);
    chk("rst_pc",    pc, 32'h0);
    chk("rst_instr", instruction, NOP);
    chk("rst_valid", {31'b0, valid}, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; freeze = vecs[i].frz; branch_taken = vecs[i].br;
      branch_addr = vecs[i].baddr; bus.imem_ready = vecs[i].rdy; bus.imem_rdata = vecs[i].rdata;
      #1;
      chk($sformatf("v%0d_req", i),  {31'b0, bus.imem_req}, {31'b0, vecs[i].e_req});
      chk($sformatf("v%0d_addr", i), bus.imem_addr, vecs[i].e_addr);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pc", i),    pc, vecs[i].e_pc);
      chk($sformatf("v%0d_instr", i), instruction, vecs[i].e_ins);
      chk($sformatf("v%0d_valid", i), {31'b0, valid}, {31'b0, vecs[i].e_v});
    end

    // Back-to-back zero-wait fetch from 0: one instruction per cycle
    rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; bus.imem_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      logic [31:0] a;
      a = 32'(k) * 32'd4;
      bus.imem_rdata = a ^ KEY;
      #1;
      chk($sformatf("tp%0d_addr", k), bus.imem_addr, a);
      @(posedge clk);
      #1;
      chk($sformatf("tp%0d_pc", k),    pc, a + 32'd4);
      chk($sformatf("tp%0d_instr", k), instruction, a ^ KEY);
      chk($sformatf("tp%0d_valid", k), {31'b0, valid}, 32'h1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
